average_unit: RTL and testbench
===============================

# average_unit

Sliding-window averager for a stream of 4-bit samples. Each `x_load` strobe captures one sample into a window of the most recent `2**LOG2N` samples and updates the window average. The 1-bit flag `y` reports whether the newest sample lies strictly above the window average. It sits downstream of a sample source as a simple spike/level detector.

## Interface
- `WIDTH`, default 4: sample width in bits. Must match the `x` port width.
- `LOG2N`, default 2: log2 of the window depth. Default depth is 4 samples.
- `clk`  input  1: single system clock. All state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high. Clears all state.
- `x_load`  input  1: sample strobe. When high at a rising edge of `clk`, `x` is captured.
- `x`  input  WIDTH: sample value, unsigned.
- `y`  output  1: registered flag. 1 means the last loaded sample is strictly greater than the current average and the window is full.
- `avg`  output  WIDTH: registered window average, computed as floor(sum / 2**LOG2N).
- `full`  output  1: registered. Goes high once 2**LOG2N samples have been loaded since reset, then stays high.

## Operation
- **State**
  - Shift register of 2**LOG2N entries, WIDTH bits each.
  - Running sum, WIDTH+LOG2N bits wide.
  - Fill counter, LOG2N+1 bits wide.
  - Output registers `y`, `avg`, `full`.
- **Reset (async, `rst`=1)**
  - Window entries, sum, counter, `y`, `avg`, `full` all go to 0 immediately, independent of `clk`.
  - While `rst` is high, `x_load` is ignored.
- **Load (`x_load`=1 at a rising edge)**
  - `x` shifts into window slot 0. The oldest entry falls out.
  - sum_next = sum + x − oldest. The oldest entry is 0 while the window is not yet full.
  - The sum must never overflow: its maximum value is (2**WIDTH−1)·2**LOG2N.
  - avg_next = sum_next >> LOG2N, which is floor division.
  - The counter increments, saturating at 2**LOG2N.
  - full_next = 1 when the counter reaches 2**LOG2N on this load.
  - y_next = full_next AND (x > avg_next). The comparison is unsigned, and `x` is the sample loaded on this same edge.
- **Idle (`x_load`=0)**: all registers hold, including `y`.
- **Before the window is full**
  - `avg` still equals sum >> LOG2N, i.e. the sum divided by the full window depth, not by the count of loaded samples.
  - `y` is forced to 0.
- **Equality**: x == avg gives y = 0.
- **`x` stable**: holding `x` constant across loads is legal. Every strobed edge is a new sample.

## Timing
- Latency: one clock. `avg`, `full` and `y` reflect a load at edge k starting just after edge k.
- Back-to-back loads are accepted on every cycle. There is no handshake and no backpressure.
- Reset assertion clears the outputs asynchronously. Deassertion is expected to be synchronous to `clk`.
- The first load is taken at the first rising edge with `rst`=0 and `x_load`=1.
- Reset in mid-stream discards the window and clears `full`. A new window must be refilled before `y` can assert.

## Test plan
- **Reset**
  - Stimulus: `rst`=1 with random `x`/`x_load`.
  - Required: `y`=0, `avg`=0, `full`=0. Outputs must clear asynchronously, without waiting for a clock edge.
- **Fill**
  - Stimulus: after reset, load 5 four times on consecutive edges.
  - Required: after the 1st load, `avg`=1, `full`=0, `y`=0. After the 4th load, `avg`=5, `full`=1, `y`=0 because 5 is not greater than 5.
- **Spike**
  - Stimulus: continue from Fill and load 9.
  - Required: window is {9,5,5,5}, sum 24, so `avg`=6 and `y`=1. Then hold `x_load`=0 for 3 cycles; `y`=1 and `avg`=6 must not change.
- **Drop / saturation**
  - Stimulus: load 15 four times, then load 0.
  - Required: after the 15s, `avg`=15, `y`=0. After the 0, sum is 45, so `avg`=11 and `y`=0. No overflow at maximum sum 60.
- **Mid-stream reset**
  - Stimulus: full window of 15s, pulse `rst`, then load 15 once.
  - Required: `full`=0, `avg`=3, `y`=0. Three more loads of 15 are needed before `full`=1.
- **Back-to-back randomized**
  - Stimulus: 1000 random `x` values with random `x_load`.
  - Required: `avg`, `y` and `full` match a reference model of the last 4 loaded samples on every cycle.

Source files
------------

// File: rtl/average_unit.sv
// average_unit: sliding-window averager over the last 2**LOG2N samples.
// Flags whether the newest sample lies strictly above the window average.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset, clears all state
//   x_load  in   sample strobe; x is captured when high at a rising edge
//   x       in   unsigned sample, WIDTH bits
//   y       out  registered: newest sample > avg and window full
//   avg     out  registered: floor(window sum / 2**LOG2N)
//   full    out  registered: 2**LOG2N samples loaded since reset (sticky)
module average_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LOG2N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_load,
    input  logic [WIDTH-1:0] x,
    output logic             y,
    output logic [WIDTH-1:0] avg,
    output logic             full
);

    localparam int unsigned DEPTH = 2 ** LOG2N;
    localparam int unsigned SUMW  = WIDTH + LOG2N;
    localparam int unsigned CNTW  = LOG2N + 1;

    logic [WIDTH-1:0] r_win [DEPTH];
    logic [SUMW-1:0]  r_sum;
    logic [CNTW-1:0]  r_cnt;
    logic             r_y;
    logic [WIDTH-1:0] r_avg;
    logic             r_full;

    logic [SUMW-1:0]  w_sum_next;
    logic [WIDTH-1:0] w_avg_next;
    logic [CNTW-1:0]  w_cnt_next;
    logic             w_full_next;
    logic             w_y_next;

    // Next-state arithmetic for a load. The oldest slot reads 0 until the
    // window has filled, because reset clears every slot, so the sum never
    // underflows and never exceeds (2**WIDTH-1)*DEPTH.
    always_comb begin
        w_sum_next  = r_sum + SUMW'(x) - SUMW'(r_win[DEPTH-1]);
        w_avg_next  = WIDTH'(w_sum_next >> LOG2N);
        w_cnt_next  = (r_cnt == CNTW'(DEPTH)) ? r_cnt : r_cnt + CNTW'(1);
        w_full_next = (w_cnt_next == CNTW'(DEPTH));
        w_y_next    = w_full_next && (x > w_avg_next);
    end

    // Window shift register, running sum, fill counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_win[i] <= '0;
            end
            r_sum  <= '0;
            r_cnt  <= '0;
            r_y    <= 1'b0;
            r_avg  <= '0;
            r_full <= 1'b0;
        end else if (x_load) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                r_win[i] <= r_win[i-1];
            end
            r_win[0] <= x;
            r_sum    <= w_sum_next;
            r_cnt    <= w_cnt_next;
            r_y      <= w_y_next;
            r_avg    <= w_avg_next;
            r_full   <= w_full_next;
        end
    end

    assign y    = r_y;
    assign avg  = r_avg;
    assign full = r_full;

endmodule

// File: tb/tb_average_unit.sv
// tb_average_unit: scoreboard bench for average_unit (WIDTH=4, LOG2N=2).
// The driver runs a window-of-samples reference model and queues the
// expected outputs for each clock edge; a monitor pops and compares them
// shortly after every rising edge.
module tb_average_unit;

    logic       clk;
    logic       rst;
    logic       x_load;
    logic [3:0] x;
    logic       y;
    logic [3:0] avg;
    logic       full;

    average_unit #(.WIDTH(4), .LOG2N(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .x_load (x_load),
        .x      (x),
        .y      (y),
        .avg    (avg),
        .full   (full)
    );

    typedef struct packed {
        logic       y;
        logic [3:0] avg;
        logic       full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the last (up to) four loaded samples.
    int win[$];
    int m_avg  = 0;
    bit m_y    = 1'b0;
    bit m_full = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model(input bit r, input bit ld, input int xv);
        int s;
        if (r) begin
            win.delete();
            m_avg  = 0;
            m_y    = 1'b0;
            m_full = 1'b0;
        end else if (ld) begin
            win.push_front(xv);
            if (win.size() > 4) void'(win.pop_back());
            s = 0;
            foreach (win[i]) s += win[i];
            m_avg  = s / 4;
            m_full = (win.size() == 4);
            m_y    = m_full && (xv > m_avg);
        end
    endfunction

    // Drive one cycle from a falling edge; returns at the following falling edge.
    task automatic step(input bit r, input bit ld, input int xv);
        exp_t e;
        rst    = r;
        x_load = ld;
        x      = 4'(xv);
        model(r, ld, xv);
        e.y    = m_y;
        e.avg  = 4'(m_avg);
        e.full = m_full;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every rising edge has exactly one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_y",    int'(y),    int'(e.y));
                check("mon_avg",  int'(avg),  int'(e.avg));
                check("mon_full", int'(full), int'(e.full));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        x_load = 1'b0;
        x      = 4'd0;
        @(negedge clk);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        check("rst_y", int'(y), 0);
        check("rst_avg", int'(avg), 0);
        check("rst_full", int'(full), 0);

        // Fill with 5s
        step(1'b0, 1'b1, 5);
        check("fill1_avg", int'(avg), 1);
        check("fill1_full", int'(full), 0);
        check("fill1_y", int'(y), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5);
        check("fill4_avg", int'(avg), 5);
        check("fill4_full", int'(full), 1);
        check("fill4_y", int'(y), 0);

        // Spike then idle hold
        step(1'b0, 1'b1, 9);
        check("spike_avg", int'(avg), 6);
        check("spike_y", int'(y), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, int'($urandom_range(0, 15)));
        check("hold_avg", int'(avg), 6);
        check("hold_y", int'(y), 1);

        // Saturation and drop
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 15);
        check("sat_avg", int'(avg), 15);
        check("sat_y", int'(y), 0);
        step(1'b0, 1'b1, 0);
        check("drop_avg", int'(avg), 11);
        check("drop_y", int'(y), 0);

        // Mid-stream reset: async clear observed before any clock edge
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 15);
        #1;
        rst = 1'b1;
        #1;
        check("async_y", int'(y), 0);
        check("async_avg", int'(avg), 0);
        check("async_full", int'(full), 0);
        @(negedge clk);
        step(1'b1, 1'b1, 15);
        step(1'b0, 1'b1, 15);
        check("refill1_full", int'(full), 0);
        check("refill1_avg", int'(avg), 3);
        check("refill1_y", int'(y), 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 15);
        check("refill3_full", int'(full), 0);
        step(1'b0, 1'b1, 15);
        check("refill4_full", int'(full), 1);

        // Randomized back-to-back traffic with occasional resets
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)));
        end

        // Drain the scoreboard within a bounded number of edges
        x_load = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
